// File: rtl/pat_his_tab_pkg.sv
// Pattern history table: shared widths, init value and FSM encoding.
// Index width matches the upstream history table so both stages agree.
package pat_his_tab_pkg;

  localparam int HIS_WIDTH = 10;
  localparam int CNT_WIDTH = 2;
  localparam int DEPTH     = 1 << HIS_WIDTH;

  localparam logic [CNT_WIDTH-1:0] INIT_CNT = 2'b01;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;

  typedef logic [HIS_WIDTH-1:0] his_t;
  typedef logic [CNT_WIDTH-1:0] cnt_t;

  // one-hot-ish encoding leaves spare codes that fall back to init
  typedef enum logic [1:0] {
    S_INIT = 2'b01,
    S_RUN  = 2'b10
  } state_t;

endpackage

// File: rtl/pat_his_tab_if.sv
// Lookup/train request and prediction bundle between the history
// stage (master) and the pattern history table (slave).
interface pat_his_tab_if;
  import pat_his_tab_pkg::*;

  logic rd_valid;
  his_t rd_his;
  logic upd_en;
  his_t upd_his;
  logic upd_taken;
  logic pred_valid;
  logic pred_taken;
  cnt_t pred_cnt;
  logic ready;

  modport master (
    output rd_valid,
    output rd_his,
    output upd_en,
    output upd_his,
    output upd_taken,
    input  pred_valid,
    input  pred_taken,
    input  pred_cnt,
    input  ready
  );

  modport slave (
    input  rd_valid,
    input  rd_his,
    input  upd_en,
    input  upd_his,
    input  upd_taken,
    output pred_valid,
    output pred_taken,
    output pred_cnt,
    output ready
  );

endinterface

// File: rtl/pat_his_tab_sat_cnt_upd.sv
// Saturating up/down next-value for one counter entry.
// Never wraps: max+taken stays max, 0+not-taken stays 0.
module sat_cnt_upd
  import pat_his_tab_pkg::*;
(
  input  cnt_t cnt_in,
  input  logic taken,
  output cnt_t cnt_out
);

  always_comb begin
    cnt_out = cnt_in;
    if (taken) begin
      if (cnt_in != CNT_MAX)
        cnt_out = cnt_in + CNT_WIDTH'(1);
    end else begin
      if (cnt_in != '0)
        cnt_out = cnt_in - CNT_WIDTH'(1);
    end
  end

endmodule

// File: rtl/pat_his_tab.sv
// Pattern history table: 2-bit counters indexed by local history,
// registered lookup, single-cycle train, post-reset init sweep.
module pat_his_tab
  import pat_his_tab_pkg::*;
(
  input logic         clk,
  input logic         reset,
  pat_his_tab_if.slave bus
);

  cnt_t   tab [DEPTH];
  state_t state;
  his_t   init_ptr;

  logic   pred_valid;
  logic   pred_taken;
  cnt_t   pred_cnt;
  logic   ready;

  logic   run;
  logic   collide;
  cnt_t   rd_cur;
  cnt_t   upd_cur;
  cnt_t   upd_nxt;
  cnt_t   byp_nxt;
  cnt_t   eff_cnt;

  assign run     = (state == S_RUN);
  assign rd_cur  = tab[bus.rd_his];
  assign upd_cur = tab[bus.upd_his];

  sat_cnt_upd u_trn (
    .cnt_in  (upd_cur),
    .taken   (bus.upd_taken),
    .cnt_out (upd_nxt)
  );

  sat_cnt_upd u_byp (
    .cnt_in  (upd_cur),
    .taken   (bus.upd_taken),
    .cnt_out (byp_nxt)
  );

  // same-cycle train to the looked-up entry: return the new value
  assign collide = bus.rd_valid & bus.upd_en
                 & (bus.rd_his == bus.upd_his);
  assign eff_cnt = collide ? byp_nxt : rd_cur;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= S_INIT;
      init_ptr   <= '0;
      pred_valid <= 1'b0;
      pred_taken <= 1'b0;
      pred_cnt   <= '0;
      ready      <= 1'b0;
    end else begin
      case (state)
        S_RUN: begin
          ready      <= 1'b1;
          pred_valid <= bus.rd_valid;
          if (bus.rd_valid) begin
            pred_cnt   <= eff_cnt;
            pred_taken <= eff_cnt[CNT_WIDTH-1];
          end
        end
        default: begin
          pred_valid <= 1'b0;
          init_ptr   <= init_ptr + HIS_WIDTH'(1);
          if (&init_ptr) begin
            state <= S_RUN;
            ready <= 1'b1;
          end else begin
            state <= S_INIT;
          end
        end
      endcase
    end
  end

  // storage has no reset; the sweep is what initialises it
  always_ff @(posedge clk) begin
    if (reset) begin
      if (run) begin
        if (bus.upd_en)
          tab[bus.upd_his] <= upd_nxt;
      end else begin
        tab[init_ptr] <= INIT_CNT;
      end
    end
  end

  assign bus.pred_valid = pred_valid;
  assign bus.pred_taken = pred_taken;
  assign bus.pred_cnt   = pred_cnt;
  assign bus.ready      = ready;

endmodule

// File: tb/tb_pat_his_tab.sv
// Self-checking bench for pat_his_tab: table model plus
// expected-prediction queue drained by an output monitor.
module tb_pat_his_tab;
  import pat_his_tab_pkg::*;

  logic clk;
  logic reset;

  pat_his_tab_if ph ();

  pat_his_tab dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ph)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string tag;
    cnt_t  cnt;
  } exp_t;

  exp_t sb [$];
  exp_t mon_e;
  cnt_t model [DEPTH];
  int   n_chk;
  int   n_fail;
  bit   mon_en;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic cnt_t sat(cnt_t c, bit t);
    if (t) return (c == 2'd3) ? 2'd3 : c + 2'd1;
    return (c == 2'd0) ? 2'd0 : c - 2'd1;
  endfunction

  task automatic model_init();
    for (int i = 0; i < DEPTH; i++) model[i] = 2'b01;
  endtask

  task automatic drive(bit rv, his_t rh, bit ue, his_t uh, bit ut,
                       string tag);
    exp_t e;
    @(negedge clk);
    ph.rd_valid  = rv;
    ph.rd_his    = rh;
    ph.upd_en    = ue;
    ph.upd_his   = uh;
    ph.upd_taken = ut;
    if (rv) begin
      e.tag = tag;
      e.cnt = (ue && rh == uh) ? sat(model[uh], ut) : model[rh];
      sb.push_back(e);
    end
    if (ue) model[uh] = sat(model[uh], ut);
  endtask

  task automatic idle();
    @(negedge clk);
    ph.rd_valid = 1'b0;
    ph.upd_en   = 1'b0;
  endtask

  task automatic drain(string tag);
    repeat (3) @(negedge clk);
    chk(tag, sb.size(), 0);
  endtask

  always @(posedge clk) begin
    #1;
    if (mon_en && ph.pred_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_pred", ph.pred_valid, 1'b0);
      end else begin
        mon_e = sb.pop_front();
        chk({mon_e.tag, "_cnt"}, ph.pred_cnt, mon_e.cnt);
        chk({mon_e.tag, "_tkn"}, ph.pred_taken, mon_e.cnt[1]);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    int p;
    n_chk  = 0;
    n_fail = 0;
    mon_en = 1'b0;
    reset  = 1'b0;
    ph.rd_valid  = 1'b0;
    ph.rd_his    = '0;
    ph.upd_en    = 1'b0;
    ph.upd_his   = '0;
    ph.upd_taken = 1'b0;
    model_init();

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", ph.ready, 1'b0);
    chk("rst_pvalid", ph.pred_valid, 1'b0);
    chk("rst_pcnt", ph.pred_cnt, 2'b00);

    @(negedge clk);
    reset       = 1'b1;
    ph.rd_valid = 1'b1;
    ph.rd_his   = '0;
    bad = (ph.ready || ph.pred_valid) ? 1 : 0;
    for (int k = 1; k < 1024; k++) begin
      @(posedge clk);
      #1;
      if (ph.ready || ph.pred_valid) bad++;
    end
    chk("init_quiet", bad, 0);
    @(posedge clk);
    #1;
    chk("init_ready", ph.ready, 1'b1);
    @(negedge clk);
    ph.rd_valid = 1'b0;
    mon_en = 1'b1;

    drive(1, 10'd0, 0, '0, 0, "init0");
    drive(1, 10'd511, 0, '0, 0, "init511");
    drive(1, 10'd1023, 0, '0, 0, "init1023");
    idle();
    drain("init_drain");

    repeat (3) drive(0, '0, 1, 10'h155, 1, "");
    drive(1, 10'h155, 0, '0, 0, "sat_up");
    drive(0, '0, 1, 10'h155, 1, "");
    drive(1, 10'h155, 0, '0, 0, "sat_up4");
    idle();
    @(posedge clk);
    #2;
    chk("hold_pvalid", ph.pred_valid, 1'b0);
    chk("hold_pcnt", ph.pred_cnt, 2'b11);

    repeat (2) drive(0, '0, 1, 10'h0AA, 0, "");
    drive(1, 10'h0AA, 0, '0, 0, "sat_dn");
    drive(0, '0, 1, 10'h0AA, 0, "");
    drive(1, 10'h0AA, 0, '0, 0, "sat_dn3");

    drive(1, 10'h3FF, 1, 10'h3FF, 1, "bypass");
    drive(1, 10'h3FF, 0, '0, 0, "bypass_after");

    drive(0, '0, 1, 10'd7, 1, "");
    drive(0, '0, 1, 10'd7, 1, "");
    drive(1, 10'd8, 0, '0, 0, "indep8");
    drive(1, 10'd7, 0, '0, 0, "indep7");
    idle();
    drain("dir_drain");

    for (int i = 0; i < 80; i++) begin
      drive(1'($urandom_range(0, 1)),
            his_t'(10'h200 + $urandom_range(0, 3)),
            1'($urandom_range(0, 1)),
            his_t'(10'h200 + $urandom_range(0, 3)),
            1'($urandom_range(0, 1)), "rand");
    end
    idle();
    drain("rand_drain");

    mon_en = 1'b0;
    @(negedge clk);
    reset       = 1'b0;
    ph.rd_valid = 1'b1;
    ph.rd_his   = 10'h155;
    @(posedge clk);
    #1;
    chk("mid_rst_ready", ph.ready, 1'b0);
    chk("mid_rst_pvalid", ph.pred_valid, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    model_init();
    bad = 0;
    p   = 0;
    while (p < 1100) begin
      @(posedge clk);
      #1;
      p++;
      if (ph.pred_valid) bad++;
      if (ph.ready) break;
    end
    chk("reinit_len", p, 1024);
    chk("reinit_quiet", bad, 0);
    @(negedge clk);
    ph.rd_valid = 1'b0;
    mon_en = 1'b1;
    drive(1, 10'h155, 0, '0, 0, "reinit155");
    drive(1, 10'h3FF, 0, '0, 0, "reinit3ff");
    idle();
    drain("final_drain");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
